// File: rtl/div_unit_pkg.sv
// Shared constants and types for the RV32M multi-cycle divider.
package div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ITERS  = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic sgn;
    logic rem;
  } op_dec_t;

endpackage

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Sits beside execute; busy stalls the front end, ready pulses writeback.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = div_unit_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        reg_waddr_o
);

  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  function automatic logic [DATA_W-1:0] abs_val(
    input logic [DATA_W-1:0] v,
    input logic              sgn
  );
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(
    input logic [DATA_W-1:0] v,
    input logic              n
  );
    return n ? -v : v;
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] dvsr;
  logic              neg_q;
  logic              neg_r;
  logic              is_rem;
  logic [4:0]        waddr_q;

  op_dec_t dec;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op_i == F3_DIV): begin
        dec.sgn = 1'b1;
      end
      (op_i == F3_REM): begin
        dec.sgn = 1'b1;
        dec.rem = 1'b1;
      end
      (op_i == F3_REMU): begin
        dec.rem = 1'b1;
      end
      default: ;
    endcase
  end

  // Trial subtract; a set carry-out bit of the shift always fits.
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              take;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quot_nxt;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  always_comb begin
    shifted  = {rem, quot[DATA_W-1]};
    diff     = shifted - {1'b0, dvsr};
    take     = shifted[DATA_W] | ~diff[DATA_W];
    rem_nxt  = take ? diff[DATA_W-1:0]
                    : shifted[DATA_W-1:0];
    quot_nxt = {quot[DATA_W-2:0], take};
    q_fix    = cond_neg(quot_nxt, neg_q);
    r_fix    = cond_neg(rem_nxt, neg_r);
  end

  assign busy_o  = (state != S_IDLE);
  assign ready_o = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      count       <= '0;
      rem         <= '0;
      quot        <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      is_rem      <= 1'b0;
      waddr_q     <= '0;
      result_o    <= '0;
      reg_waddr_o <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_i && !cancel_i) begin
            is_rem  <= dec.rem;
            waddr_q <= reg_waddr_i;
            neg_q   <= dec.sgn
                     & (dividend_i[DATA_W-1]
                     ^ divisor_i[DATA_W-1]);
            neg_r   <= dec.sgn
                     & dividend_i[DATA_W-1];
            if (divisor_i == '0) begin
              result_o    <= dec.rem ? dividend_i : '1;
              reg_waddr_o <= reg_waddr_i;
              state       <= S_DONE;
            end else begin
              quot  <= abs_val(dividend_i, dec.sgn);
              dvsr  <= abs_val(divisor_i, dec.sgn);
              rem   <= '0;
              count <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cancel_i) begin
            state <= S_IDLE;
          end else begin
            rem   <= rem_nxt;
            quot  <= quot_nxt;
            count <= count + 1'b1;
            if (count == LAST) begin
              result_o    <= is_rem ? r_fix : q_fix;
              reg_waddr_o <= waddr_q;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: latency, signed fix-up,
// divide-by-zero, cancel, held start, back-to-back, async reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        cancel_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .op_i(op_i),
    .dividend_i(dividend_i),
    .divisor_i(divisor_i),
    .reg_waddr_i(reg_waddr_i),
    .cancel_i(cancel_i),
    .busy_o(busy_o),
    .ready_o(ready_o),
    .result_o(result_o),
    .reg_waddr_o(reg_waddr_o)
  );

  function automatic logic [31:0] ref_res(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic rm;
    sgn = ~op[0];
    rm = op[1];
    if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return rm ? 32'h0 : 32'h8000_0000;
    if (sgn)
      return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rm ? a % b : a / b;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one op from IDLE, wait for the pulse, pop the scoreboard.
  // Returns in the first IDLE cycle after DONE.
  task automatic run_op(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] wa, output int lat,
    output logic [31:0] res, output logic [31:0] exp_r,
    output logic [4:0] gwa, output logic [4:0] exp_wa);
    logic [36:0] e;
    op_i = op;
    dividend_i = a;
    divisor_i = b;
    reg_waddr_i = wa;
    start_i = 1'b1;
    sb_q.push_back({wa, ref_res(op, a, b)});
    step(1);
    start_i = 1'b0;
    lat = 1;
    while (!ready_o && lat < 100) begin
      step(1);
      lat++;
    end
    if (ready_o) begin
      res = result_o;
      gwa = reg_waddr_o;
    end else begin
      lat = -1;
      res = 'x;
      gwa = 'x;
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      exp_wa = e[36:32];
      exp_r = e[31:0];
    end else begin
      exp_wa = 5'h1F;
      exp_r = ~res;
    end
    step(1);
  endtask

  task automatic test_reset();
    start_i = 1'b1;
    op_i = F3_DIVU;
    divisor_i = 32'd3;
    step(3);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", busy_o);
    end
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b want 0", ready_o);
    end
    n_checks++;
    if (result_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_result got %h want 0", result_o);
    end
    n_checks++;
    if (reg_waddr_o !== 5'h0) begin
      n_fail++; $display("FAIL reset_waddr got %h want 0", reg_waddr_o);
    end
    start_i = 1'b0;
    rst = 1'b1;
    step(2);
  endtask

  task automatic test_divu();
    int lat;
    logic [31:0] r, er;
    logic [4:0] w, ew;
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd5, lat, r, er, w, ew);
    n_checks++;
    if (lat !== 33) begin
      n_fail++; $display("FAIL divu_lat got %0d want 33", lat);
    end
    n_checks++;
    if (r !== er || r !== 32'd14) begin
      n_fail++; $display("FAIL divu_res got %h want %h", r, er);
    end
    n_checks++;
    if (w !== ew) begin
      n_fail++; $display("FAIL divu_waddr got %h want %h", w, ew);
    end
    n_checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL divu_pulse got ready %b busy %b want 0 0", ready_o, busy_o);
    end
    run_op(F3_REMU, 32'd100, 32'd7, 5'd6, lat, r, er, w, ew);
    n_checks++;
    if (r !== er || r !== 32'd2 || lat !== 33) begin
      n_fail++; $display("FAIL remu_res got %h lat %0d want %h lat 33", r, lat, er);
    end
  endtask

  task automatic test_signed();
    logic [2:0]  ops[8] = '{F3_DIV, F3_REM, F3_REM, F3_DIV, F3_REM,
                            F3_DIV, F3_REMU, F3_DIVU};
    logic [31:0] as[8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                           32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF9C,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[8] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd3, 32'd1};
    logic [31:0] want[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                             32'h8000_0000, 32'd0, 32'd14, 32'd0,
                             32'hFFFF_FFFF};
    int lat;
    logic [31:0] r, er;
    logic [4:0] w, ew;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 16), lat, r, er, w, ew);
      n_checks++;
      if (r !== er || r !== want[i] || w !== ew || lat !== 33) begin
        n_fail++;
        $display("FAIL signed_%0d got %h wa %h lat %0d want %h wa %h lat 33",
                 i, r, w, lat, want[i], ew);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [31:0] r, er;
    logic [4:0] w, ew;
    run_op(F3_DIV, 32'd5, 32'd0, 5'd7, lat, r, er, w, ew);
    n_checks++;
    if (r !== er || r !== 32'hFFFF_FFFF || lat !== 1 || w !== ew) begin
      n_fail++; $display("FAIL dz_div got %h lat %0d want ffffffff lat 1", r, lat);
    end
    run_op(F3_REM, 32'hFFFF_FFFB, 32'd0, 5'd8, lat, r, er, w, ew);
    n_checks++;
    if (r !== er || r !== 32'hFFFF_FFFB || lat !== 1 || w !== ew) begin
      n_fail++; $display("FAIL dz_rem got %h lat %0d want fffffffb lat 1", r, lat);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] r0;
    logic [4:0] w0;
    int lat;
    logic [31:0] r, er;
    logic [4:0] w, ew;
    r0 = result_o;
    w0 = reg_waddr_o;
    op_i = F3_DIVU;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    reg_waddr_i = 5'd9;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(9);
    n_checks++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
      n_fail++; $display("FAIL cancel_inflight got busy %b ready %b want 1 0", busy_o, ready_o);
    end
    cancel_i = 1'b1;
    step(1);
    cancel_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++; $display("FAIL cancel_idle got busy %b ready %b want 0 0", busy_o, ready_o);
    end
    n_checks++;
    if (result_o !== r0 || reg_waddr_o !== w0) begin
      n_fail++; $display("FAIL cancel_hold got %h/%h want %h/%h", result_o, reg_waddr_o, r0, w0);
    end
    run_op(F3_DIV, 32'd12345, 32'hFFFF_FFFB, 5'd11, lat, r, er, w, ew);
    n_checks++;
    if (r !== er || w !== ew || lat !== 33) begin
      n_fail++; $display("FAIL cancel_next got %h wa %h lat %0d want %h wa %h lat 33", r, w, lat, er, ew);
    end
  endtask

  task automatic test_held_start();
    int pulses;
    logic [31:0] r;
    logic [36:0] e;
    op_i = F3_DIVU;
    dividend_i = 32'd77;
    divisor_i = 32'd5;
    reg_waddr_i = 5'd3;
    start_i = 1'b1;
    sb_q.push_back({5'd3, ref_res(F3_DIVU, 32'd77, 32'd5)});
    step(1);
    step(20);
    start_i = 1'b0;
    pulses = 0;
    r = 'x;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (ready_o) begin
        pulses++;
        r = result_o;
      end
    end
    e = sb_q.pop_front();
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL held_pulses got %0d want 1", pulses);
    end
    n_checks++;
    if (r !== e[31:0]) begin
      n_fail++; $display("FAIL held_res got %h want %h", r, e[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] r, er;
    logic [4:0] w, ew;
    for (int i = 0; i < 3; i++) begin
      run_op(F3_REMU, 32'd1000 + 32'(i * 37), 32'd9 + 32'(i), 5'(20 + i),
             lat, r, er, w, ew);
      n_checks++;
      if (r !== er || w !== ew || lat !== 33) begin
        n_fail++; $display("FAIL b2b_%0d got %h wa %h lat %0d want %h wa %h lat 33", i, r, w, lat, er, ew);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    logic [31:0] r, er;
    logic [4:0] w, ew;
    op_i = F3_DIV;
    dividend_i = 32'd999;
    divisor_i = 32'd4;
    reg_waddr_i = 5'd13;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(5);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'h0 || reg_waddr_o !== 5'h0) begin
      n_fail++;
      $display("FAIL rst_mid got busy %b ready %b res %h wa %h want all 0",
               busy_o, ready_o, result_o, reg_waddr_o);
    end
    step(1);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ready_o) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_quiet got pulses %0d busy %b want 0 0", pulses, busy_o);
    end
    run_op(F3_DIVU, 32'd64, 32'd8, 5'd1, lat, r, er, w, ew);
    n_checks++;
    if (r !== er || w !== ew || lat !== 33) begin
      n_fail++; $display("FAIL rst_recover got %h lat %0d want %h lat 33", r, lat, er);
    end
  endtask

  task automatic test_random();
    int lat;
    int want_lat;
    logic [2:0] op;
    logic [31:0] a, b, r, er;
    logic [4:0] w, ew;
    for (int i = 0; i < 12; i++) begin
      op = 3'(3'd4 + 3'($urandom_range(0, 3)));
      a = $urandom;
      case (i % 4)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom | 32'd1;
      endcase
      want_lat = (b == 32'd0) ? 1 : 33;
      run_op(op, a, b, 5'($urandom_range(0, 31)), lat, r, er, w, ew);
      n_checks++;
      if (r !== er || w !== ew || lat !== want_lat) begin
        n_fail++;
        $display("FAIL rand_%0d op %b %h/%h got %h wa %h lat %0d want %h wa %h lat %0d",
                 i, op, a, b, r, w, lat, er, ew, want_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_cancel();
    test_held_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the execute stage, downstream of id_ex. The execute logic issues a start with operands. The divider holds busy_o high so the pipeline control can stall fetch/decode. It returns the result with the destination register address on a one-cycle ready_o pulse, which feeds the ex_mem writeback path. It computes one restoring-division bit per cycle.

## Interface
Parameters:
- DATA_W, 32, operand and result width. Only 32 is supported.

Ports:
- clk  input  1  core clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- start_i  input  1  request a division; sampled only in IDLE
- op_i  input  3  funct3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
- dividend_i  input  32  rs1 value, captured on accepted start
- divisor_i  input  32  rs2 value, captured on accepted start
- reg_waddr_i  input  5  destination register, captured on accepted start
- cancel_i  input  1  abort an in-flight operation (branch/jump flush)
- busy_o  output  1  high whenever state ≠ IDLE
- ready_o  output  1  one-cycle pulse; result_o/reg_waddr_o valid
- result_o  output  32  quotient or remainder; holds until next completion
- reg_waddr_o  output  5  destination register of the completed operation

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC: start_i=1 and cancel_i=0 with a non-zero divisor. Capture op, reg_waddr, the sign flags and |dividend|, |divisor|. Signed ops take the absolute value; unsigned ops use the operands raw. Clear the remainder accumulator and load count=0.
- IDLE → DONE (fast path): start_i=1, cancel_i=0, divisor_i==0. result = 32'hFFFF_FFFF for DIV/DIVU, dividend_i unmodified for REM/REMU.
- CALC: each cycle, shift {rem,quot} left by one and trial-subtract the divisor from a 33-bit remainder. If the difference is non-negative, keep it and set the quotient LSB to 1. Increment count. After the 32nd iteration, go to DONE.
- Sign fix-up on entry to DONE:
  - Signed quotient is negated iff the dividend and divisor signs differ.
  - Signed remainder is negated iff the dividend is negative.
  - Overflow (-2^31 / -1) falls out naturally: quotient 32'h8000_0000, remainder 0. No special path.
- DONE: ready_o=1 for exactly one cycle, then IDLE unconditionally.
- cancel_i=1 in CALC: next state IDLE, no ready_o, result_o/reg_waddr_o keep their previous values.
- cancel_i=1 in IDLE: the start is ignored.
- cancel_i=1 in DONE: no effect; the pulse has already been issued. The flush logic must discard it.
- start_i while busy_o=1 is ignored. It does not queue.

## Timing
- Reset (rst=0, async): state IDLE; busy_o=0, ready_o=0, result_o=0, reg_waddr_o=0; count, accumulators and flags cleared.
- Normal path: start accepted in cycle N → CALC in cycles N+1..N+32 → DONE (ready_o=1) in cycle N+33. Latency is 33 cycles; busy_o is high N+1..N+33.
- Fast path (divisor 0): start in N → ready_o=1 in N+1. busy_o is high in N+1 only.
- busy_o and ready_o decode directly from the state register, with no input-to-output combinational path.
- result_o and reg_waddr_o are registered and update on the edge entering DONE.
- Back-to-back: a new start may be presented in the cycle after DONE (first IDLE cycle). The throughput limit is one op per 34 cycles.

## Structure
- Shared package/defines:
  - funct3 constants DIV/DIVU/REM/REMU
  - state encoding (2-bit)
  - DATA_W
  - iteration count constant 32
- Single module. No sub-module is needed: the absolute-value and negate logic is small enough to stay inline as functions.

## Test plan
- DIVU 100 / 7: start → ready_o exactly 33 cycles later; result 14; then REMU same operands → 2.
- DIV -7 / 2 → -3 (32'hFFFF_FFFD); REM -7 / 2 → -1; REM 7 / -2 → 1.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000; REM same → 0; latency 33.
- Divide by zero: DIV 5/0 → 32'hFFFF_FFFF, REM -5/0 → 32'hFFFF_FFFB, each with ready_o one cycle after start.
- cancel_i at CALC cycle 10 → busy_o low next cycle, no ready_o, result_o unchanged. A start_i held during busy produces no second result. A start in the cycle after cancel completes normally.
- rst asserted mid-CALC → all outputs 0 immediately. After release, no ready_o until a fresh start.
